// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pkg.sv
// Shared types and width helpers for the gf180mcu clocked buffer-pipe slice.
package gf180mcu_fd_sc_mcu7t5v0__pkg;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_PARTIAL, BUF_FULL} buf_state_t;

    function automatic int buf_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int buf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe_mem.sv
// DEPTH x WIDTH storage for the buffer pipe: synchronous write, asynchronous read, no reset.
module gf180mcu_fd_sc_mcu7t5v0__buf_pipe_mem
    import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = buf_ptr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe.sv
// Elastic valid/ready buffer for retiming long nets between macros.
// Optional zero-latency empty bypass: define GF180MCU_BUF_PIPE_BYPASS_EN.
module gf180mcu_fd_sc_mcu7t5v0__buf_pipe
    import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = buf_ptr_w(DEPTH),
    localparam int CW    = buf_cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VLD,
    output logic             I_RDY,
    output logic [WIDTH-1:0] Z,
    output logic             Z_VLD,
    input  logic             Z_RDY,
    output logic [CW-1:0]    CNT
);

    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_alive;
    buf_state_t       w_state;
    logic             w_byp;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    always_comb begin
        if (r_cnt == '0) begin
            w_state = BUF_EMPTY;
        end else if (r_cnt == L_FULL) begin
            w_state = BUF_FULL;
        end else begin
            w_state = BUF_PARTIAL;
        end
    end

`ifdef GF180MCU_BUF_PIPE_BYPASS_EN
    assign w_byp = r_alive && (w_state == BUF_EMPTY) && I_VLD;
`else
    assign w_byp = 1'b0;
`endif

    // r_alive holds I_RDY low until the first edge after reset release.
    assign I_RDY  = r_alive && (w_state != BUF_FULL);
    assign w_push = I_VLD && I_RDY && !(w_byp && Z_RDY);
    assign w_pop  = (w_state != BUF_EMPTY) && Z_RDY;

    assign Z_VLD = (w_state != BUF_EMPTY) || w_byp;
    assign Z     = w_byp ? I : ((w_state != BUF_EMPTY) ? w_rdata : '0);
    assign CNT   = r_cnt;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_alive  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    gf180mcu_fd_sc_mcu7t5v0__buf_pipe_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (I),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

endmodule
